// File: rtl/alu_exec_unit.sv
// alu_exec_unit: two-stage valid/ready ALU pipeline.
// S1 registers the operands and opcode. S2 registers the result and flags.
// Optional feature: define ALU_OVF_EN to add the Overflow output
// (signed overflow of ADD/SUB).
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  AluSig,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Result,
  output logic        Zero,
`ifdef ALU_OVF_EN
  output logic        Illegal,
  output logic        Overflow
`else
  output logic        Illegal
`endif
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Stage S1: captured operands and opcode
  logic        s1_valid_r;
  logic [31:0] s1_a_r;
  logic [31:0] s1_b_r;
  logic [2:0]  s1_op_r;

  // Stage S2: registered result and flags
  logic        s2_valid_r;
  logic [31:0] result_r;
  logic        illegal_r;
  logic        ovf_r;

  // Combinational execute datapath between S1 and S2
  logic [31:0] sum_s;
  logic [31:0] diff_s;
  logic [31:0] res_s;
  logic        ill_s;
  logic        ovf_s;
  logic        s2_adv_s;

  // S2 can take a new beat when it is empty or its beat leaves this cycle.
  // S1 can advance (and accept input) when it is empty or S2 advances.
  assign s2_adv_s = !s2_valid_r || out_ready;
  assign in_ready = !s1_valid_r || s2_adv_s;

  // Decode the opcode and compute the wrapped 32-bit result for the beat in S1
  always_comb begin
    sum_s  = s1_a_r + s1_b_r;
    diff_s = s1_a_r - s1_b_r;
    res_s  = 32'd0;
    ill_s  = 1'b0;
    case (s1_op_r)
      OP_AND:  res_s = s1_a_r & s1_b_r;
      OP_OR:   res_s = s1_a_r | s1_b_r;
      OP_ADD:  res_s = sum_s;
      OP_NOR:  res_s = ~(s1_a_r | s1_b_r);
      OP_SUB:  res_s = diff_s;
      OP_SLT:  res_s = ($signed(s1_a_r) < $signed(s1_b_r)) ? 32'd1 : 32'd0;
      default: begin
        res_s = 32'd0;
        ill_s = 1'b1;
      end
    endcase
  end

`ifdef ALU_OVF_EN
  // Signed overflow: result sign disagrees with what the operand signs imply
  always_comb begin
    ovf_s = 1'b0;
    if (s1_op_r == OP_ADD) begin
      ovf_s = (s1_a_r[31] == s1_b_r[31]) && (sum_s[31] != s1_a_r[31]);
    end else if (s1_op_r == OP_SUB) begin
      ovf_s = (s1_a_r[31] != s1_b_r[31]) && (diff_s[31] != s1_a_r[31]);
    end else begin
      ovf_s = 1'b0;
    end
  end
`else
  assign ovf_s = 1'b0;
`endif

  // S1 register: load a new beat whenever the stage may advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= 32'd0;
      s1_b_r     <= 32'd0;
      s1_op_r    <= 3'b000;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_a_r  <= A;
        s1_b_r  <= B;
        s1_op_r <= AluSig;
      end
    end
  end

  // S2 register: take the computed result; hold it while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      result_r   <= 32'd0;
      illegal_r  <= 1'b0;
      ovf_r      <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        result_r  <= res_s;
        illegal_r <= ill_s;
        ovf_r     <= ovf_s;
      end
    end
  end

  assign out_valid = s2_valid_r;
  assign Result    = result_r;
  // Zero is taken from the registered result so it always matches Result
  assign Zero      = (result_r == 32'd0);
  assign Illegal   = illegal_r;
`ifdef ALU_OVF_EN
  assign Overflow  = ovf_r;
`else
  // ovf_r stays constant 0 in this build and is intentionally left unread
  logic unused_ovf_s;
  assign unused_ovf_s = ovf_r;
`endif

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operand/opcode beat present.
REQ-005 in_ready  output  1  block accepts a beat this cycle.
REQ-006 AluSig  input  3  operation code from ALU control.
REQ-007 A, B  input  32 each  operands, two's complement.
REQ-008 out_valid  output  1  result beat present.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 Result  output  32  operation result.
REQ-011 Zero  output  1  high when Result == 0.
REQ-012 Illegal  output  1  high when the beat carried an undefined AluSig.
REQ-013 Overflow  output  1  signed overflow of add/sub; present only with ALU_OVF_EN.

Function
REQ-014 AluSig decode SHALL be: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed, Result = 1 or 0), 100 NOR; 011 and 101 are illegal.
REQ-015 Illegal codes SHALL produce Result = 0, Zero = 1, Illegal = 1, Overflow = 0.
REQ-016 Arithmetic SHALL be 32-bit modulo 2^32; carry out discarded.
REQ-017 A beat SHALL transfer on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-018 The block SHALL be a two-stage pipeline: stage S1 registers A, B, AluSig; stage S2 registers Result and flags.
REQ-019 Latency SHALL be exactly 2 cycles from input transfer to out_valid with no backpressure; throughput one beat per cycle.
REQ-020 Each stage SHALL advance when it is empty or its downstream stage advances in the same cycle.
REQ-021 in_ready SHALL equal !S1_valid || S1 advancing; it SHALL NOT depend on in_valid.
REQ-022 When out_valid && !out_ready, Result and all flags SHALL hold stable until the transfer.
REQ-023 With both stages full and out_ready low, in_ready SHALL be 0 and no beat is lost or duplicated.
REQ-024 Simultaneous output transfer and input transfer with both stages full SHALL shift the pipeline with no bubble.
REQ-025 Beats SHALL leave in acceptance order.
REQ-026 Zero SHALL be computed from the registered Result value.

Reset
REQ-027 Asserting rst_n low SHALL immediately clear S1_valid and S2_valid, forcing out_valid = 0, in_ready = 1 after reset.
REQ-028 During reset Result SHALL be 0, Zero 1, Illegal 0, Overflow 0.
REQ-029 Beats in flight at reset assertion SHALL be discarded; the first beat accepted after release obeys REQ-019.

Configuration
REQ-030 Macro ALU_OVF_EN SHALL control overflow detection.
REQ-031 With ALU_OVF_EN defined: Overflow port exists; set for ADD when A, B same sign and sum sign differs, for SUB when A, B differ in sign and difference sign differs from A; 0 for other ops; Result still wraps.
REQ-032 Without ALU_OVF_EN: Overflow port and its logic are absent; all other behaviour identical.

Verification
REQ-033 Reset then ADD A=5 B=7, out_ready=1 -> out_valid high 2 cycles later, Result=12, Zero=0, Illegal=0.
REQ-034 SUB A=3 B=3 -> Result=0, Zero=1; SLT A=0xFFFFFFFF B=1 -> Result=1; NOR A=0 B=0 -> Result=0xFFFFFFFF.
REQ-035 ALU_OVF_EN defined, ADD A=0x7FFFFFFF B=1 -> Result=0x80000000, Overflow=1; SUB A=0x80000000 B=1 -> Result=0x7FFFFFFF, Overflow=1.
REQ-036 Hold out_ready=0, stream 4 beats (AND, OR, 011, ADD) -> in_ready drops after 2 accepted, Result stable; release out_ready -> all 4 emerge in order, beat 3 Result=0 Illegal=1.
REQ-037 Continuous in_valid and out_ready toggling every cycle -> no loss, no duplication, order preserved versus reference model.
REQ-038 Assert rst_n low mid-stream with 2 beats in flight -> out_valid=0 same cycle, in_ready=1 after release, no stale beat emerges.
